// File: rtl/icache_mem_adapter_tagged.sv
// ICache downstream memory adapter with a tagged table of outstanding line fetches.
// Memory beats are reassembled into lines and returned upstream with their sideband.
module icache_mem_adapter_tagged #(
  parameter int ADDR_W      = 32,
  parameter int SIDE_W      = 16,
  parameter int LINE_W      = 256,
  parameter int BEAT_W      = 64,
  parameter int OUTSTANDING = 4,
  parameter int TAG_W       = $clog2(OUTSTANDING)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             up_req_vld,
  output logic                             up_req_rdy,
  input  logic [ADDR_W-1:0]                up_req_addr,
  input  logic [SIDE_W-1:0]                up_req_side,
  output logic                             up_rsp_vld,
  input  logic                             up_rsp_rdy,
  output logic [LINE_W-1:0]                up_rsp_data,
  output logic [SIDE_W-1:0]                up_rsp_side,
  output logic                             mem_req_vld,
  input  logic                             mem_req_rdy,
  output logic [ADDR_W-1:0]                mem_req_addr,
  output logic [TAG_W-1:0]                 mem_req_tag,
  input  logic                             mem_ack_vld,
  output logic                             mem_ack_rdy,
  input  logic [BEAT_W-1:0]                mem_ack_data,
  input  logic [TAG_W-1:0]                 mem_ack_tag,
  input  logic                             mem_ack_last,
  output logic [$clog2(OUTSTANDING+1)-1:0] outstanding_cnt,
  output logic                             err_unexp,
  output logic                             err_last
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int BC_W  = $clog2(BEATS);
  localparam int CNT_W = $clog2(OUTSTANDING + 1);

  typedef enum logic [1:0] {
    E_IDLE,
    E_WAIT,
    E_DONE
  } ent_e;

  ent_e st_q [OUTSTANDING];
  ent_e st_d [OUTSTANDING];

  logic [BC_W-1:0]                bcnt_q [OUTSTANDING];
  logic [SIDE_W-1:0]              side_q [OUTSTANDING];
  logic [BEATS-1:0][BEAT_W-1:0]   data_q [OUTSTANDING];

  logic [TAG_W-1:0] rr_q, sel_q;
  logic [TAG_W-1:0] alloc_idx, pick_idx;
  logic             sel_vld_q;
  logic             free_any, done_any;
  logic             req_fire, rsp_fire;
  logic             ack_fire, ack_ok, ack_hit, ack_full;
  logic [BC_W-1:0]  ack_cnt;
  logic             err_unexp_q, err_last_q;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    free_any  = 1'b0;
    alloc_idx = '0;
    for (int i = OUTSTANDING - 1; i >= 0; i--) begin
      if (st_q[i] == E_IDLE) begin
        free_any  = 1'b1;
        alloc_idx = TAG_W'(i);
      end
    end
  end

  // scanned backwards so the entry nearest rr_q wins
  always_comb begin
    int j;
    j        = 0;
    done_any = 1'b0;
    pick_idx = '0;
    for (int k = OUTSTANDING - 1; k >= 0; k--) begin
      j = (int'(rr_q) + k) % OUTSTANDING;
      if (st_q[j] == E_DONE) begin
        done_any = 1'b1;
        pick_idx = TAG_W'(j);
      end
    end
  end

  assign up_req_rdy   = mem_req_rdy && free_any && !rst;
  assign mem_req_vld  = up_req_vld && free_any;
  assign mem_req_addr = up_req_addr;
  assign mem_req_tag  = alloc_idx;
  assign req_fire     = up_req_vld && up_req_rdy;

  assign mem_ack_rdy = !rst;
  assign ack_fire    = mem_ack_vld && mem_ack_rdy;
  assign ack_ok      = {1'b0, mem_ack_tag} < (TAG_W + 1)'(OUTSTANDING);
  assign ack_hit     = ack_fire && ack_ok &&
                       st_q[mem_ack_tag] == E_WAIT;
  assign ack_cnt     = bcnt_q[mem_ack_tag];
  assign ack_full    = ack_cnt == BC_W'(BEATS - 1);

  assign rsp_fire    = sel_vld_q && up_rsp_rdy;
  assign up_rsp_vld  = sel_vld_q;
  assign up_rsp_data = sel_vld_q ? data_q[sel_q] : '0;
  assign up_rsp_side = sel_vld_q ? side_q[sel_q] : '0;

  // allocate, complete and release always hit distinct entries
  always_comb begin
    for (int i = 0; i < OUTSTANDING; i++) st_d[i] = st_q[i];
    if (req_fire) st_d[alloc_idx] = E_WAIT;
    if (ack_hit && ack_full) st_d[mem_ack_tag] = E_DONE;
    if (rsp_fire) st_d[sel_q] = E_IDLE;
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < OUTSTANDING; i++) begin
      if (st_q[i] != E_IDLE) cnt = cnt + CNT_W'(1);
    end
  end

  assign outstanding_cnt = cnt;
  assign err_unexp       = err_unexp_q;
  assign err_last        = err_last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OUTSTANDING; i++) st_q[i] <= E_IDLE;
      rr_q        <= '0;
      sel_q       <= '0;
      sel_vld_q   <= 1'b0;
      err_unexp_q <= 1'b0;
      err_last_q  <= 1'b0;
    end else begin
      for (int i = 0; i < OUTSTANDING; i++) st_q[i] <= st_d[i];
      if (rsp_fire) begin
        sel_vld_q <= 1'b0;
        rr_q      <= (sel_q == TAG_W'(OUTSTANDING - 1)) ?
                     '0 : sel_q + 1'b1;
      end else if (!sel_vld_q && done_any) begin
        sel_vld_q <= 1'b1;
        sel_q     <= pick_idx;
      end
      if (ack_fire && !ack_hit) err_unexp_q <= 1'b1;
      if (ack_hit && (mem_ack_last != ack_full)) err_last_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      side_q[alloc_idx] <= up_req_side;
      bcnt_q[alloc_idx] <= '0;
    end
    if (ack_hit) begin
      data_q[mem_ack_tag][ack_cnt] <= mem_ack_data;
      bcnt_q[mem_ack_tag]          <= ack_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_mem_adapter_tagged.sv
// Bench for icache_mem_adapter_tagged: directed scenarios, then random
// traffic scored against a per-tag line model.
module tb_icache_mem_adapter_tagged;

  localparam int OUT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         up_req_vld, up_req_rdy;
  logic [31:0]  up_req_addr;
  logic [15:0]  up_req_side;
  logic         up_rsp_vld, up_rsp_rdy;
  logic [255:0] up_rsp_data;
  logic [15:0]  up_rsp_side;
  logic         mem_req_vld, mem_req_rdy;
  logic [31:0]  mem_req_addr;
  logic [1:0]   mem_req_tag;
  logic         mem_ack_vld, mem_ack_rdy;
  logic [63:0]  mem_ack_data;
  logic [1:0]   mem_ack_tag;
  logic         mem_ack_last;
  logic [2:0]   outstanding_cnt;
  logic         err_unexp, err_last;

  int n_chk = 0;
  int n_err = 0;

  bit           m_busy [OUT];
  bit           m_done [OUT];
  int           m_nb   [OUT];
  logic [15:0]  m_side [OUT];
  logic [255:0] m_line [OUT];
  logic [15:0]  side_ctr = 16'h8000;

  always #5 clk = ~clk;

  icache_mem_adapter_tagged dut (
    .clk             (clk),
    .rst             (rst),
    .up_req_vld      (up_req_vld),
    .up_req_rdy      (up_req_rdy),
    .up_req_addr     (up_req_addr),
    .up_req_side     (up_req_side),
    .up_rsp_vld      (up_rsp_vld),
    .up_rsp_rdy      (up_rsp_rdy),
    .up_rsp_data     (up_rsp_data),
    .up_rsp_side     (up_rsp_side),
    .mem_req_vld     (mem_req_vld),
    .mem_req_rdy     (mem_req_rdy),
    .mem_req_addr    (mem_req_addr),
    .mem_req_tag     (mem_req_tag),
    .mem_ack_vld     (mem_ack_vld),
    .mem_ack_rdy     (mem_ack_rdy),
    .mem_ack_data    (mem_ack_data),
    .mem_ack_tag     (mem_ack_tag),
    .mem_ack_last    (mem_ack_last),
    .outstanding_cnt (outstanding_cnt),
    .err_unexp       (err_unexp),
    .err_last        (err_last)
  );

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic beat(input int t, input logic [63:0] d,
                      input bit last);
    mem_ack_vld  = 1'b1;
    mem_ack_tag  = 2'(t);
    mem_ack_data = d;
    mem_ack_last = last;
    step();
    mem_ack_vld  = 1'b0;
    mem_ack_last = 1'b0;
  endtask

  task automatic wait_rsp(input int max);
    int n;
    n = 0;
    while (!up_rsp_vld && n < max) begin
      step();
      n++;
    end
    check("rsp_wait", up_rsp_vld, 1);
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic int model_cnt();
    int c;
    c = 0;
    for (int i = 0; i < OUT; i++) if (m_busy[i]) c++;
    return c;
  endfunction

  task automatic rnd_cycle(input bit req_en);
    int ack_t, s, t, f, lo;
    step();
    check("rnd_cnt", outstanding_cnt, model_cnt());
    ack_t = -1;
    if ($urandom_range(0, 9) < 7) begin
      s = $urandom_range(0, OUT - 1);
      for (int k = 0; k < OUT; k++) begin
        t = (s + k) % OUT;
        if (ack_t < 0 && m_busy[t] && m_nb[t] < 4) ack_t = t;
      end
    end
    up_req_vld  = req_en && ($urandom_range(0, 1) == 1);
    up_req_addr = $urandom;
    up_req_side = side_ctr;
    mem_req_rdy = ($urandom_range(0, 3) != 0);
    up_rsp_rdy  = req_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    mem_ack_vld = (ack_t >= 0);
    if (ack_t >= 0) begin
      mem_ack_tag  = 2'(ack_t);
      mem_ack_data = m_line[ack_t][m_nb[ack_t]*64 +: 64];
      mem_ack_last = (m_nb[ack_t] == 3);
    end else begin
      mem_ack_last = 1'b0;
    end
    #1;
    check("rnd_req_rdy", up_req_rdy,
          mem_req_rdy && (model_cnt() < OUT));
    if (up_req_vld && up_req_rdy) begin
      lo = -1;
      for (int i = OUT - 1; i >= 0; i--) if (!m_busy[i]) lo = i;
      check("rnd_tag", mem_req_tag, lo);
      check("rnd_addr", mem_req_addr, up_req_addr);
      if (lo >= 0) begin
        m_busy[lo] = 1'b1;
        m_done[lo] = 1'b0;
        m_nb[lo]   = 0;
        m_side[lo] = up_req_side;
        m_line[lo] = rnd_line();
      end
      side_ctr = side_ctr + 16'd1;
    end
    if (up_rsp_vld && up_rsp_rdy) begin
      f = -1;
      for (int i = 0; i < OUT; i++)
        if (m_busy[i] && m_done[i] && m_side[i] == up_rsp_side) f = i;
      check("rnd_rsp_known", (f >= 0), 1);
      if (f >= 0) begin
        check("rnd_rsp_data", up_rsp_data, m_line[f]);
        m_busy[f] = 1'b0;
        m_done[f] = 1'b0;
      end
    end
    if (ack_t >= 0) begin
      m_nb[ack_t]++;
      if (m_nb[ack_t] == 4) m_done[ack_t] = 1'b1;
    end
  endtask

  initial begin
    logic [255:0] l0, l1, l2, l5;
    logic [255:0] line1;
    int           seq [8];
    int           c [OUT];
    int           t, n;
    bit           any;

    rst = 1'b1;
    up_req_vld = 0; up_req_addr = 0; up_req_side = 0;
    up_rsp_rdy = 0; mem_req_rdy = 0;
    mem_ack_vld = 0; mem_ack_data = 0; mem_ack_tag = 0;
    mem_ack_last = 0;
    step();
    step();
    mem_req_rdy = 1; up_req_vld = 1;
    #1;
    check("rst_req_rdy", up_req_rdy, 0);
    check("rst_ack_rdy", mem_ack_rdy, 0);
    check("rst_rsp_vld", up_rsp_vld, 0);
    check("rst_rsp_data", up_rsp_data, 0);
    check("rst_cnt", outstanding_cnt, 0);
    check("rst_errs", {err_unexp, err_last}, 0);
    up_req_vld = 0;
    step();
    rst = 1'b0;

    // single fetch
    up_req_vld = 1; up_req_addr = 32'h1000; up_req_side = 16'hABCD;
    #1;
    check("t1_req_vld", mem_req_vld, 1);
    check("t1_req_rdy", up_req_rdy, 1);
    check("t1_tag", mem_req_tag, 0);
    check("t1_addr", mem_req_addr, 32'h1000);
    step();
    up_req_vld = 0;
    #1;
    check("t1_cnt1", outstanding_cnt, 1);
    beat(0, 64'h1111_1111_1111_1111, 0);
    beat(0, 64'h2222_2222_2222_2222, 0);
    beat(0, 64'h3333_3333_3333_3333, 0);
    beat(0, 64'h4444_4444_4444_4444, 1);
    check("t1_vld_early", up_rsp_vld, 0);
    step();
    line1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    check("t1_vld", up_rsp_vld, 1);
    check("t1_data", up_rsp_data, line1);
    check("t1_side", up_rsp_side, 16'hABCD);
    up_rsp_rdy = 1;
    step();
    up_rsp_rdy = 0;
    check("t1_cnt0", outstanding_cnt, 0);
    check("t1_vld_off", up_rsp_vld, 0);

    // fill the table, fifth request stalls
    up_req_vld = 1;
    for (int i = 0; i < 4; i++) begin
      up_req_side = 16'h2000 + 16'(i);
      #1;
      check("t2_rdy", up_req_rdy, 1);
      check("t2_tag", mem_req_tag, i);
      step();
    end
    up_req_side = 16'h2004;
    #1;
    check("t2_full_rdy", up_req_rdy, 0);
    check("t2_full_vld", mem_req_vld, 0);
    check("t2_full_cnt", outstanding_cnt, 4);
    l1 = rnd_line();
    for (int b = 0; b < 4; b++) beat(1, l1[b*64 +: 64], b == 3);
    wait_rsp(10);
    check("t2_side", up_rsp_side, 16'h2001);
    check("t2_data", up_rsp_data, l1);
    up_rsp_rdy = 1;
    #1;
    check("t2_no_reuse", up_req_rdy, 0);
    step();
    up_rsp_rdy = 0;
    #1;
    check("t2_reuse_rdy", up_req_rdy, 1);
    check("t2_reuse_tag", mem_req_tag, 1);
    step();
    up_req_vld = 0;
    #1;
    check("t2_cnt", outstanding_cnt, 4);

    // interleaved beats, tag 2 finishes first; then back-pressure
    l2 = rnd_line();
    l0 = rnd_line();
    seq = '{2, 0, 2, 0, 2, 2, 0, 0};
    for (int i = 0; i < OUT; i++) c[i] = 0;
    for (int k = 0; k < 8; k++) begin
      t = seq[k];
      beat(t, (t == 2) ? l2[c[t]*64 +: 64] : l0[c[t]*64 +: 64],
           c[t] == 3);
      c[t]++;
    end
    wait_rsp(10);
    check("t3_first_side", up_rsp_side, 16'h2002);
    check("t3_first_data", up_rsp_data, l2);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_hold_vld", up_rsp_vld, 1);
      check("t4_hold_data", up_rsp_data, l2);
      check("t4_hold_side", up_rsp_side, 16'h2002);
    end
    up_rsp_rdy = 1;
    step();
    up_rsp_rdy = 0;
    check("t4_gap", up_rsp_vld, 0);
    wait_rsp(10);
    check("t4_next_side", up_rsp_side, 16'h2000);
    check("t4_next_data", up_rsp_data, l0);
    up_rsp_rdy = 1;
    step();
    up_rsp_rdy = 0;
    check("t4_cnt", outstanding_cnt, 2);

    // reset with two entries waiting
    rst = 1;
    up_req_vld = 1; mem_req_rdy = 1; up_req_side = 16'h5555;
    step();
    #1;
    check("t6_rst_rdy", up_req_rdy, 0);
    check("t6_rst_ack_rdy", mem_ack_rdy, 0);
    rst = 0;
    #1;
    check("t6_cnt", outstanding_cnt, 0);
    check("t6_vld", up_rsp_vld, 0);
    check("t6_data", up_rsp_data, 0);
    check("t6_side", up_rsp_side, 0);
    check("t6_errs", {err_unexp, err_last}, 0);
    check("t6_tag", mem_req_tag, 0);
    check("t6_rdy", up_req_rdy, 1);
    step();
    up_req_vld = 0;

    // stale beat, then a misplaced last flag
    beat(3, 64'hDEAD_BEEF, 1);
    #1;
    check("t5_unexp", err_unexp, 1);
    check("t5_last_clr", err_last, 0);
    any = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      any = any | up_rsp_vld;
    end
    check("t5_no_rsp", any, 0);
    l5 = rnd_line();
    for (int b = 0; b < 4; b++) begin
      beat(0, l5[b*64 +: 64], b == 1);
      if (b == 1) check("t5_err_last", err_last, 1);
    end
    wait_rsp(10);
    check("t5_data", up_rsp_data, l5);
    check("t5_side", up_rsp_side, 16'h5555);
    up_rsp_rdy = 1;
    step();
    up_rsp_rdy = 0;
    check("t5_cnt", outstanding_cnt, 0);
    rst = 1;
    step();
    rst = 0;
    check("t5_errs_clr", {err_unexp, err_last}, 0);

    // random traffic
    for (int i = 0; i < OUT; i++) begin
      m_busy[i] = 0; m_done[i] = 0; m_nb[i] = 0;
    end
    for (int i = 0; i < 3000; i++) rnd_cycle(1'b1);
    n = 0;
    while (model_cnt() != 0 && n < 500) begin
      rnd_cycle(1'b0);
      n++;
    end
    check("rnd_drained", model_cnt(), 0);
    step();
    check("rnd_cnt_end", outstanding_cnt, 0);
    check("rnd_errs", {err_unexp, err_last}, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/icache_mem_adapter_tagged.md
Name: icache_mem_adapter_tagged

Overview:
- Parametrised successor to the ICache downstream memory adapter.
- Sits between the ICache MSHR downstream port and the memory model. Allows up to OUTSTANDING concurrent line fetches, each tracked by a memory tag.
- Packs the ICache sideband (lineA/opcode/MSHR idx/txnid, opaque here) into a local tag table, so the memory sees only a TAG_W tag.
- Memory returns each line as BEAT_W beats, possibly out of order across tags. The block reassembles full LINE_W lines and returns them upstream with the original sideband.

Parameters:
- ADDR_W, 32, request address width.
- SIDE_W, 16, opaque sideband width; stored at request, returned with the line.
- LINE_W, 256, upstream line width.
- BEAT_W, 64, memory beat width; LINE_W must be an integer multiple. BEATS = LINE_W/BEAT_W, must be ≥ 2.
- OUTSTANDING, 4, tag-table depth, ≥ 2.
- TAG_W, $clog2(OUTSTANDING), memory tag width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- up_req_vld  in  1  ICache fetch request valid
- up_req_rdy  out  1  request accepted when vld&&rdy
- up_req_addr  in  ADDR_W  line address
- up_req_side  in  SIDE_W  sideband to preserve
- up_rsp_vld  out  1  assembled line valid
- up_rsp_rdy  in  1  ICache accepts line
- up_rsp_data  out  LINE_W  assembled line
- up_rsp_side  out  SIDE_W  sideband of that line
- mem_req_vld  out  1  memory request valid
- mem_req_rdy  in  1  memory accepts
- mem_req_addr  out  ADDR_W  = up_req_addr
- mem_req_tag  out  TAG_W  allocated tag
- mem_ack_vld  in  1  beat valid
- mem_ack_rdy  out  1  beat accepted
- mem_ack_data  in  BEAT_W  beat data
- mem_ack_tag  in  TAG_W  beat tag
- mem_ack_last  in  1  memory marks final beat
- outstanding_cnt  out  $clog2(OUTSTANDING+1)  allocated entries
- err_unexp  out  1  sticky: beat to unallocated or already-complete tag
- err_last  out  1  sticky: mem_ack_last inconsistent with beat count

Behaviour:
- Reset (rst=1 at clk edge):
  - All entries invalid; round-robin pointer = 0; sel_vld = 0.
  - Outputs: up_rsp_vld=0, up_rsp_data=0, up_rsp_side=0, outstanding_cnt=0, err_unexp=0, err_last=0.
  - mem_ack_rdy=0 and up_req_rdy=0 while rst=1.
  - Reset mid-operation discards all in-flight entries. Beats arriving after reset for old tags raise err_unexp.
- Entry state: IDLE → WAIT (allocated, beat_cnt counting) → DONE (line complete) → IDLE (on upstream handshake).
- Request path (combinational pass-through):
  - free_any = any entry IDLE, taken from registered state; an entry freed this cycle is not reusable until next cycle.
  - mem_req_vld = up_req_vld && free_any.
  - up_req_rdy = mem_req_rdy && free_any.
  - mem_req_tag = lowest-index IDLE entry.
  - On handshake, that entry → WAIT; latch side; beat_cnt=0.
- Response path:
  - mem_ack_rdy = 1 whenever not in reset; beats are never back-pressured.
  - Accepted beat to a WAIT tag: write data into bits [beat_cnt*BEAT_W +: BEAT_W]; beat_cnt++.
  - When beat_cnt was BEATS-1, entry → DONE.
  - err_last sets if mem_ack_last=1 with beat_cnt≠BEATS-1, or mem_ack_last=0 with beat_cnt=BEATS-1. Beat is still written and completion is still governed by beat_cnt.
  - Beat to an IDLE or DONE tag: dropped, err_unexp set, no state change.
  - Beats of different tags may interleave in any order.
- Output select:
  - When sel_vld=0 and any entry is DONE, register sel_idx = first DONE entry at or after the rr pointer (wrapping), and set sel_vld=1.
  - up_rsp_vld = sel_vld. up_rsp_data and up_rsp_side are driven from entry sel_idx and held stable while vld && !rdy.
  - On handshake: entry → IDLE, sel_vld=0, rr pointer = sel_idx+1 mod OUTSTANDING.
  - Back-to-back responses therefore take ≥ 2 cycles each.
  - Latency: last beat accepted at edge T → DONE visible in cycle T+1 → up_rsp_vld in cycle T+2 if sel was free.
- outstanding_cnt: number of non-IDLE entries.
  - Same-cycle allocate and free leave it unchanged.
  - Never exceeds OUTSTANDING; when it equals OUTSTANDING, up_req_rdy=0.
- A beat completing an entry in the same cycle as a different entry's upstream handshake: both take effect.

Test Plan:
1. Single fetch, defaults. Req addr 0x1000, side 0xABCD → mem_req_tag=0. Beats 0x11..,0x22..,0x33..,0x44.. with last on the 4th → up_rsp_data = {beat3,beat2,beat1,beat0}, side 0xABCD, up_rsp_vld 2 cycles after last beat; outstanding_cnt 1→0.
2. Full table: 5 back-to-back requests with mem_req_rdy=1 → tags 0,1,2,3 issued; 5th stalls (up_req_rdy=0, cnt=4) until the first response handshake; the freed tag is issued the cycle after.
3. Out-of-order, interleaved beats: tags 2 and 0 interleaved, tag 2 finishing first → tag 2 line returned first, then tag 0; each line intact with its own sideband.
4. Back-pressure: up_rsp_rdy=0 for 5 cycles while two entries are DONE → data/side stable, sel_idx unchanged; after release, round-robin returns the other entry next.
5. Errors: beat to unallocated tag 3 → err_unexp=1, no upstream response. mem_ack_last on beat 1 → err_last=1, line still completes after 4 beats.
6. Reset asserted with 2 entries in WAIT → all outputs 0, cnt=0. A new request after reset gets tag 0.
